palette_stream_mapper: RTL

- Sits between the port1 DDR read stream and the HDMI pixel input.
- Consumes 32-bit point words, each carrying a Mandelbrot iteration count.
- Maps each count to 24-bit RGB through a 3-stage pipeline and a selectable palette, then buffers the result in an output FIFO.
- Delivers one pixel per cycle when HDMI requests it, and gates HDMI start on FIFO prefill.

---
 rtl/palette_stream_mapper.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/palette_stream_mapper.sv
// Maps Mandelbrot iteration counts to 24-bit RGB through a 3-stage palette
// pipeline and buffers the pixels in a FIFO that feeds the HDMI pixel input.
module palette_stream_mapper #(
  parameter int FIFO_DEPTH   = 16,
  parameter int PREFILL      = 12,
  parameter int FRAME_PIXELS = 786432
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        update,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] max_iter,
  input  logic [1:0]  palette_sel,
  input  logic        stream_data,
  output logic [23:0] data_out,
  output logic        data_out_valid,
  output logic        start_output,
  output logic        end_frame,
  output logic        underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);
  localparam logic [PW-1:0] PIX_LAST  = PW'(FRAME_PIXELS - 1);

  logic          flush;
  logic          block_q;
  logic          accept;

  logic          s1_valid;
  logic [15:0]   s1_iter;
  logic          s2_valid;
  logic          s2_in_set;
  logic [7:0]    s2_idx;
  logic [1:0]    s2_sel;
  logic          s3_valid;
  logic [23:0]   s3_rgb;
  logic [23:0]   palette_rgb;

  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] occupancy;
  logic [1:0]    inflight;
  logic          push;
  logic          pop;
  logic [PW-1:0] pix_cnt;

  logic          unused_hi;
  assign unused_hi = ^in_data[31:16];

  assign flush    = reset | update;
  assign inflight = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, s3_valid};
  assign occupancy = fifo_count + CW'(inflight);
  // Words already in the pipeline reserve their FIFO slot, so a push never overflows.
  assign in_ready = !flush && !block_q && (occupancy < DEPTH_C);
  assign accept   = in_valid && in_ready;

  assign push       = s3_valid;
  assign pop        = stream_data && (fifo_count != '0);
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  always_comb begin
    palette_rgb = 24'h000000;
    if (!s2_in_set) begin
      case (s2_sel)
        2'd0:    palette_rgb = {s2_idx, s2_idx, s2_idx};
        2'd1:    palette_rgb = {(s2_idx[7] ? 8'hFF : {s2_idx[6:0], 1'b0}),
                                s2_idx, {s2_idx[7:6], 6'b000000}};
        2'd2:    palette_rgb = {2'b00, s2_idx[7:2], s2_idx, ~s2_idx};
        default: palette_rgb = {{8{s2_idx[0]}}, {8{s2_idx[1]}}, {8{s2_idx[2]}}};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= s3_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      block_q        <= 1'b1;
      s1_valid       <= 1'b0;
      s1_iter        <= '0;
      s2_valid       <= 1'b0;
      s2_in_set      <= 1'b0;
      s2_idx         <= '0;
      s2_sel         <= '0;
      s3_valid       <= 1'b0;
      s3_rgb         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      pix_cnt        <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      start_output   <= 1'b0;
      end_frame      <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      block_q  <= 1'b0;
      s1_valid <= accept;
      if (accept) begin
        s1_iter <= in_data[15:0];
      end

      s2_valid  <= s1_valid;
      s2_in_set <= (s1_iter >= max_iter);
      s2_idx    <= s1_iter[7:0];
      s2_sel    <= palette_sel;

      s3_valid <= s2_valid;
      s3_rgb   <= palette_rgb;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      fifo_count <= count_next;
      if (count_next >= PREFILL_C) begin
        start_output <= 1'b1;
      end

      // Empty is judged on the registered count; a same-cycle push cannot be popped.
      if (stream_data) begin
        if (fifo_count != '0) begin
          rd_ptr         <= rd_ptr + AW'(1);
          data_out       <= fifo_mem[rd_ptr];
          data_out_valid <= 1'b1;
          if (pix_cnt == PIX_LAST) begin
            pix_cnt   <= '0;
            end_frame <= 1'b1;
          end else begin
            pix_cnt   <= pix_cnt + PW'(1);
            end_frame <= 1'b0;
          end
        end else begin
          data_out       <= '0;
          data_out_valid <= 1'b0;
          end_frame      <= 1'b0;
          underflow      <= 1'b1;
        end
      end else begin
        data_out_valid <= 1'b0;
        end_frame      <= 1'b0;
      end
    end
  end

endmodule
